// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg : FSM encodings and defaults for the MEM-stage access unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mau_state_e;

    localparam int unsigned C_TIMEOUT_CYC_DEFAULT = 64;

endpackage

`default_nettype wire

// File: rtl/mem_timeout_cnt.sv
// ---------------------------------------------------------------------------
// mem_timeout_cnt : cycle counter that runs while enabled, clears when idle,
// and flags expiry on the LIMIT-th enabled cycle. Built only with MEM_TIMEOUT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifdef MEM_TIMEOUT_EN
module mem_timeout_cnt #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned C_CW = $clog2(LIMIT + 1);

    logic [C_CW-1:0] cnt_q;

    // Dropping the enable is the clear: the count only spans REQ+WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i) begin
            cnt_q <= '0;
        end else if (!expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = en_i && (cnt_q == C_CW'(LIMIT - 1));

endmodule
`endif

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit : MEM-stage data-memory access with req/gnt/rvalid handshake,
// upstream stall and branch resolution. Optional timeout: MEM_TIMEOUT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = C_TIMEOUT_CYC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RegWrite_in,
    input  logic          MemtoReg_in,
    input  logic          MemWrite_in,
    input  logic          MemRead_in,
    input  logic          Branch_in,
    input  logic          Zero_in,
    input  logic [31:0]   pc_in,
    input  logic [31:0]   ALU_in,
    input  logic [DW-1:0] WD_in,
    input  logic [4:0]    WN_in,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_gnt,
    input  logic          dmem_rvalid,
    input  logic [DW-1:0] dmem_rdata,
    output logic          stall,
    output logic          PCSrc,
    output logic [31:0]   br_target,
    output logic          RegWrite_out,
    output logic          MemtoReg_out,
    output logic [DW-1:0] RD_out,
    output logic [31:0]   ALU_out,
    output logic [4:0]    WN_out,
    output logic          mem_err
);

    mau_state_e    state_q;
    logic          req_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rd_q;
    logic          err_q;
    logic          w_memop;
    logic          w_expire;

    assign w_memop = MemRead_in | MemWrite_in;

`ifdef MEM_TIMEOUT_EN
    logic w_cnt_en;
    assign w_cnt_en = (state_q == ST_REQ) || (state_q == ST_WAIT);

    mem_timeout_cnt #(
        .LIMIT    (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (w_cnt_en),
        .expire_o (w_expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign w_expire       = 1'b0;
`endif

    // A handshake completing on the expiry cycle wins over the abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_memop) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        we_q    <= ~MemRead_in;
                        addr_q  <= ALU_in[AW-1:0];
                        wdata_q <= WD_in;
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? ST_DONE : ST_WAIT;
                    end else if (w_expire) begin
                        req_q   <= 1'b0;
                        rd_q    <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        rd_q    <= dmem_rdata;
                        state_q <= ST_DONE;
                    end else if (w_expire) begin
                        rd_q    <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall        = w_memop && (state_q != ST_DONE);
    assign PCSrc        = Branch_in & Zero_in & ~stall;
    assign br_target    = pc_in;
    assign RegWrite_out = RegWrite_in & ~stall & ~err_q;
    assign MemtoReg_out = MemtoReg_in;
    assign ALU_out      = ALU_in;
    assign WN_out       = WN_in;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign RD_out       = rd_q;
    assign mem_err      = err_q;

endmodule

`default_nettype wire
